capture_readout: RTL

Downstream of the logic capture stage. After a capture completes, this block reads the captured 8-bit samples back out of the shared capture BRAM through its second port. It streams them as a framed byte sequence over a valid/ready byte interface to the UART transmitter, for host-side decode.
- Frame layout: header byte, 24-bit sample count, samples, optional checksum.

---
 rtl/capture_readout.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/capture_readout.sv
// Streams captured BRAM samples as a framed byte sequence: header, 24-bit count, samples.
// Define READOUT_CHECKSUM_EN to append an 8-bit running sum of count and sample bytes.
module capture_readout #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 8,
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] sample_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    StIdle, StHdr, StCnt2, StCnt1, StCnt0, StRdReq, StRdWait, StSend,
`ifdef READOUT_CHECKSUM_EN
    StCsum,
`endif
    StFin
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W:0]   idx_q;    // one bit wider so a full-range count cannot wrap
  logic [1:0]        wait_q;
  logic [23:0]       cnt24;
  logic [ADDR_W:0]   idx_inc;
  logic              hs;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign cnt24   = 24'(count_q);
  assign idx_inc = idx_q + (ADDR_W+1)'(1);
  assign hs      = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state_q  <= StIdle;
      rd_en    <= 1'b0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            count_q  <= sample_count;
            idx_q    <= '0;
            rd_addr  <= '0;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StHdr;
          end
        end
        StHdr: if (hs) begin
          tx_data <= cnt24[23:16];
          state_q <= StCnt2;
        end
        StCnt2: if (hs) begin
          tx_data <= cnt24[15:8];
          state_q <= StCnt1;
        end
        StCnt1: if (hs) begin
          tx_data <= cnt24[7:0];
          state_q <= StCnt0;
        end
        StCnt0: if (hs) begin
          if (count_q != '0) begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= idx_q[ADDR_W-1:0];
            state_q  <= StRdReq;
          end else begin
`ifdef READOUT_CHECKSUM_EN
            tx_data  <= csum_q + tx_data;
            state_q  <= StCsum;
`else
            tx_valid <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StFin;
`endif
          end
        end
        StRdReq: begin
          rd_en   <= 1'b0;
          wait_q  <= 2'(RD_LATENCY - 1);
          state_q <= StRdWait;
        end
        StRdWait: begin
          if (wait_q == 2'd0) begin
            tx_data  <= rd_data;
            tx_valid <= 1'b1;
            state_q  <= StSend;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        StSend: if (hs) begin
          idx_q <= idx_inc;
          if (idx_inc == {1'b0, count_q}) begin
`ifdef READOUT_CHECKSUM_EN
            tx_data  <= csum_q + tx_data;
            state_q  <= StCsum;
`else
            tx_valid <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StFin;
`endif
          end else begin
            tx_valid <= 1'b0;
            rd_en    <= 1'b1;
            rd_addr  <= idx_inc[ADDR_W-1:0];
            state_q  <= StRdReq;
          end
        end
`ifdef READOUT_CHECKSUM_EN
        StCsum: if (hs) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StFin;
        end
`endif
        StFin: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef READOUT_CHECKSUM_EN
  // Header is excluded: only count and sample bytes accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state_q == StIdle && start) begin
      csum_q <= '0;
    end else if (hs && (state_q == StCnt2 || state_q == StCnt1 || state_q == StCnt0 ||
                        state_q == StSend)) begin
      csum_q <= csum_q + tx_data;
    end
  end
`endif

endmodule
